// File: rtl/mcu_ctrl_pkg.sv
// Shared constants for the MCU-32X multi-cycle controller: state codes, opcodes,
// ALU operation codes and PC source selects.
package mcu_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StFetch     = 3'd0;
  localparam state_t StDecode    = 3'd1;
  localparam state_t StExecute   = 3'd2;
  localparam state_t StMemory    = 3'd3;
  localparam state_t StWriteback = 3'd4;
  localparam state_t StTrap      = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  function automatic logic op_known(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: op_known = 1'b1;
      default:                                              op_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcu_wait_timer.sv
// Bus wait-state counter: counts unacknowledged cycles and flags when the
// count reaches TIMEOUT. TIMEOUT = 0 never flags.
module mcu_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic ack,
  output logic timeout
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT);

  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !ack && (count_q != '1)) begin
      // Saturate so a disabled timeout cannot wrap back into range.
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout = (TIMEOUT != 0) && (count_q == Limit);

endmodule

// File: rtl/mcu_multicycle_ctrl.sv
// Multi-cycle control FSM for the MCU-32X core: handshaked fetch and data access
// with wait-state timeout, latched IR decode, sticky traps and retire counter.
module mcu_multicycle_ctrl
  import mcu_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instruction,
  input  logic                  ifetch_ack,
  input  logic                  mem_ack,
  input  logic                  alu_zero,
  output logic                  ifetch_req,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  alu_src_imm,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_to_reg,
  output logic                  reg_dst,
  output logic                  reg_write,
  output logic                  illegal_op,
  output logic                  bus_error,
  output logic [CNT_W-1:0]      instr_retired
);

  state_t           state_q, state_d;
  logic [31:0]      ir_q;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q, bus_err_q;

  logic [5:0] op;
  logic       is_lw;
  logic       retire, set_illegal, set_bus_err;
  logic       wait_state, timer_ack, timed_out;

  // Unregistered control values before the reset gate.
  logic                  ifr_c, irw_c, pcw_c, imm_c, mr_c, mw_c, m2r_c, rd_c, rw_c;
  logic [1:0]            pcs_c;
  logic [ALU_CTRL_W-1:0] alu_c;

  logic unused_ir_bits;
  assign unused_ir_bits = ^ir_q[25:ALU_CTRL_W];

  assign op    = ir_q[31:26];
  assign is_lw = (op == OP_LW);

  always_comb begin
    state_d     = state_q;
    ifr_c       = 1'b0;
    irw_c       = 1'b0;
    pcw_c       = 1'b0;
    pcs_c       = PC_SRC_SEQ;
    alu_c       = '0;
    imm_c       = 1'b0;
    mr_c        = 1'b0;
    mw_c        = 1'b0;
    m2r_c       = 1'b0;
    rd_c        = 1'b0;
    rw_c        = 1'b0;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    wait_state  = 1'b0;
    timer_ack   = 1'b0;

    unique case (state_q)
      StFetch: begin
        ifr_c      = 1'b1;
        wait_state = 1'b1;
        timer_ack  = ifetch_ack;
        if (ifetch_ack) begin
          irw_c   = 1'b1;
          pcw_c   = 1'b1;
          pcs_c   = PC_SRC_SEQ;
          state_d = StDecode;
        end else if (timed_out) begin
          set_bus_err = 1'b1;
          state_d     = StTrap;
        end
      end

      StDecode: begin
        if (op_known(op)) begin
          state_d = StExecute;
        end else begin
          set_illegal = 1'b1;
          state_d     = StTrap;
        end
      end

      StExecute: begin
        case (op)
          OP_RTYPE: begin
            alu_c   = ir_q[ALU_CTRL_W-1:0];
            state_d = StWriteback;
          end
          OP_ADDI: begin
            alu_c   = ALU_CTRL_W'(ALU_ADD);
            imm_c   = 1'b1;
            state_d = StWriteback;
          end
          OP_LW, OP_SW: begin
            alu_c   = ALU_CTRL_W'(ALU_ADD);
            imm_c   = 1'b1;
            state_d = StMemory;
          end
          OP_BEQ, OP_BNE: begin
            alu_c   = ALU_CTRL_W'(ALU_SUB);
            pcs_c   = PC_SRC_BRANCH;
            pcw_c   = (op == OP_BEQ) ? alu_zero : !alu_zero;
            retire  = 1'b1;
            state_d = StFetch;
          end
          OP_J: begin
            pcw_c   = 1'b1;
            pcs_c   = PC_SRC_JUMP;
            retire  = 1'b1;
            state_d = StFetch;
          end
          default: begin
            set_illegal = 1'b1;
            state_d     = StTrap;
          end
        endcase
      end

      StMemory: begin
        wait_state = 1'b1;
        timer_ack  = mem_ack;
        mr_c       = is_lw;
        mw_c       = !is_lw;
        if (mem_ack) begin
          if (is_lw) begin
            state_d = StWriteback;
          end else begin
            retire  = 1'b1;
            state_d = StFetch;
          end
        end else if (timed_out) begin
          set_bus_err = 1'b1;
          state_d     = StTrap;
        end
      end

      StWriteback: begin
        rw_c    = 1'b1;
        rd_c    = (op == OP_RTYPE);
        m2r_c   = is_lw;
        retire  = 1'b1;
        state_d = StFetch;
      end

      StTrap: begin
        state_d = StTrap;
      end

      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // Any state change clears the count, so each FETCH/MEMORY visit starts at zero.
  mcu_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_d != state_q),
    .enable (wait_state),
    .ack    (timer_ack),
    .timeout(timed_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (irw_c) begin
        ir_q <= instruction;
      end
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      if (set_illegal) begin
        illegal_q <= 1'b1;
      end
      if (set_bus_err) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  // Every output reads zero for the whole reset cycle.
  always_comb begin
    ifetch_req    = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 2'b00;
    alu_control   = '0;
    alu_src_imm   = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    illegal_op    = 1'b0;
    bus_error     = 1'b0;
    instr_retired = '0;
    if (!reset) begin
      ifetch_req    = ifr_c;
      ir_write      = irw_c;
      pc_write      = pcw_c;
      pc_src        = pcs_c;
      alu_control   = alu_c;
      alu_src_imm   = imm_c;
      mem_read      = mr_c;
      mem_write     = mw_c;
      mem_to_reg    = m2r_c;
      reg_dst       = rd_c;
      reg_write     = rw_c;
      illegal_op    = illegal_q;
      bus_error     = bus_err_q;
      instr_retired = retired_q;
    end
  end

endmodule

// File: tb/tb_mcu_multicycle_ctrl.sv
// Directed bench for mcu_multicycle_ctrl: walks each instruction class cycle by cycle
// and checks the full control vector plus the retire counter against hand values.
module tb_mcu_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic        ifetch_ack = 1'b0;
  logic        mem_ack = 1'b0;
  logic        alu_zero = 1'b0;
  logic        ifetch_req, ir_write, pc_write, alu_src_imm;
  logic        mem_read, mem_write, mem_to_reg, reg_dst, reg_write, illegal_op, bus_error;
  logic [1:0]  pc_src;
  logic [3:0]  alu_control;
  logic [3:0]  instr_retired;

  int checks = 0;
  int errors = 0;

  mcu_multicycle_ctrl #(
    .ALU_CTRL_W(4),
    .TIMEOUT   (15),
    .CNT_W     (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .instruction  (instruction),
    .ifetch_ack   (ifetch_ack),
    .mem_ack      (mem_ack),
    .alu_zero     (alu_zero),
    .ifetch_req   (ifetch_req),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_control  (alu_control),
    .alu_src_imm  (alu_src_imm),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_to_reg   (mem_to_reg),
    .reg_dst      (reg_dst),
    .reg_write    (reg_write),
    .illegal_op   (illegal_op),
    .bus_error    (bus_error),
    .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  // {ifetch_req, ir_write, pc_write, pc_src, alu_control, alu_src_imm, mem_read,
  //  mem_write, mem_to_reg, reg_dst, reg_write, illegal_op, bus_error}
  logic [16:0] ctl;
  assign ctl = {ifetch_req, ir_write, pc_write, pc_src, alu_control, alu_src_imm, mem_read,
                mem_write, mem_to_reg, reg_dst, reg_write, illegal_op, bus_error};

  localparam logic [16:0] B_IFR   = 17'h10000;
  localparam logic [16:0] B_IRW   = 17'h08000;
  localparam logic [16:0] B_PCW   = 17'h04000;
  localparam logic [16:0] PCS_BR  = 17'h01000;
  localparam logic [16:0] PCS_J   = 17'h02000;
  localparam logic [16:0] A_ADD   = 17'h00200;
  localparam logic [16:0] A_SUB   = 17'h00600;
  localparam logic [16:0] A_OR    = 17'h00500;
  localparam logic [16:0] B_IMM   = 17'h00080;
  localparam logic [16:0] B_MR    = 17'h00040;
  localparam logic [16:0] B_MW    = 17'h00020;
  localparam logic [16:0] B_M2R   = 17'h00010;
  localparam logic [16:0] B_RD    = 17'h00008;
  localparam logic [16:0] B_RW    = 17'h00004;
  localparam logic [16:0] B_ILL   = 17'h00002;
  localparam logic [16:0] B_BE    = 17'h00001;

  localparam logic [16:0] VZ      = 17'h00000;
  localparam logic [16:0] VF      = B_IFR;
  localparam logic [16:0] VFA     = B_IFR | B_IRW | B_PCW;
  localparam logic [16:0] VEX_IMM = A_ADD | B_IMM;
  localparam logic [16:0] VBR_T   = A_SUB | PCS_BR | B_PCW;
  localparam logic [16:0] VBR_N   = A_SUB | PCS_BR;
  localparam logic [16:0] VJ      = B_PCW | PCS_J;

  localparam logic [31:0] I_RADD = 32'h00221820;
  localparam logic [31:0] I_ROR  = 32'h00221825;
  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_SW   = 32'hAC220004;
  localparam logic [31:0] I_ADDI = 32'h20220005;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_BNE  = 32'h14220003;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_BAD  = 32'hFC000000;
  // Illegal opcode on the live bus after fetch: decode must use the latched IR.
  localparam logic [31:0] I_JUNK = 32'hFFFFFFFF;

  // One clock: drive inputs at the falling edge, sample 1 ns later.
  task automatic cyc(input string tag, input logic rst, input logic ifa, input logic ma,
                     input logic z, input logic [31:0] ins, input logic [16:0] exp);
    @(negedge clk);
    reset       = rst;
    ifetch_ack  = ifa;
    mem_ack     = ma;
    alu_zero    = z;
    instruction = ins;
    #1;
    checks++;
    assert (ctl === exp) else begin
      errors++;
      $error("FAIL %s: ctl=%05h expected %05h", tag, ctl, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [3:0] exp);
    checks++;
    assert (instr_retired === exp) else begin
      errors++;
      $error("FAIL %s: instr_retired=%0d expected %0d", tag, instr_retired, exp);
    end
  endtask

  initial begin
    // Reset with busy inputs: everything must read zero.
    cyc("rst0", 1, 1, 1, 1, I_RADD, VZ);
    chk_cnt("rst0_cnt", 4'd0);
    cyc("rst1", 1, 1, 1, 1, I_RADD, VZ);

    // R-type add: 4 cycles.
    cyc("radd_f", 0, 1, 0, 0, I_RADD, VFA);
    chk_cnt("radd_f_cnt", 4'd0);
    cyc("radd_d", 0, 0, 0, 0, I_JUNK, VZ);
    cyc("radd_e", 0, 0, 1, 0, I_JUNK, VZ);
    cyc("radd_wb", 0, 0, 0, 0, I_JUNK, B_RD | B_RW);
    cyc("radd_next", 0, 0, 0, 0, I_JUNK, VF);
    chk_cnt("radd_cnt", 4'd1);

    // lw with three wait states: mem_read held four cycles, 8 cycles total.
    cyc("lw_f", 0, 1, 0, 0, I_LW, VFA);
    cyc("lw_d", 0, 0, 0, 0, I_JUNK, VZ);
    cyc("lw_e", 0, 0, 0, 0, I_JUNK, VEX_IMM);
    cyc("lw_m0", 0, 1, 0, 0, I_JUNK, B_MR);
    cyc("lw_m1", 0, 0, 0, 0, I_JUNK, B_MR);
    cyc("lw_m2", 0, 0, 0, 0, I_JUNK, B_MR);
    cyc("lw_m3", 0, 0, 1, 0, I_JUNK, B_MR);
    cyc("lw_wb", 0, 0, 0, 0, I_JUNK, B_M2R | B_RW);

    // Branches: 3 cycles each.
    cyc("beq1_f", 0, 1, 0, 0, I_BEQ, VFA);
    chk_cnt("lw_cnt", 4'd2);
    cyc("beq1_d", 0, 0, 0, 0, I_JUNK, VZ);
    cyc("beq1_e", 0, 0, 0, 1, I_JUNK, VBR_T);
    cyc("beq0_f", 0, 1, 0, 0, I_BEQ, VFA);
    chk_cnt("beq1_cnt", 4'd3);
    cyc("beq0_d", 0, 0, 0, 1, I_JUNK, VZ);
    cyc("beq0_e", 0, 0, 0, 0, I_JUNK, VBR_N);
    cyc("bne0_f", 0, 1, 0, 0, I_BNE, VFA);
    chk_cnt("beq0_cnt", 4'd4);
    cyc("bne0_d", 0, 0, 0, 1, I_JUNK, VZ);
    cyc("bne0_e", 0, 0, 0, 0, I_JUNK, VBR_T);
    cyc("bne1_f", 0, 1, 0, 0, I_BNE, VFA);
    chk_cnt("bne0_cnt", 4'd5);
    cyc("bne1_d", 0, 0, 0, 0, I_JUNK, VZ);
    cyc("bne1_e", 0, 0, 0, 1, I_JUNK, VBR_N);

    // addi, R-type or, sw without wait, j.
    cyc("addi_f", 0, 1, 0, 0, I_ADDI, VFA);
    chk_cnt("bne1_cnt", 4'd6);
    cyc("addi_d", 0, 0, 0, 0, I_JUNK, VZ);
    cyc("addi_e", 0, 0, 0, 0, I_JUNK, VEX_IMM);
    cyc("addi_wb", 0, 0, 0, 0, I_JUNK, B_RW);
    cyc("ror_f", 0, 1, 0, 0, I_ROR, VFA);
    chk_cnt("addi_cnt", 4'd7);
    cyc("ror_d", 0, 0, 0, 0, I_JUNK, VZ);
    cyc("ror_e", 0, 0, 0, 0, I_JUNK, A_OR);
    cyc("ror_wb", 0, 0, 0, 0, I_JUNK, B_RD | B_RW);
    cyc("sw_f", 0, 1, 0, 0, I_SW, VFA);
    chk_cnt("ror_cnt", 4'd8);
    cyc("sw_d", 0, 0, 0, 0, I_JUNK, VZ);
    cyc("sw_e", 0, 0, 0, 0, I_JUNK, VEX_IMM);
    cyc("sw_m", 0, 0, 1, 0, I_JUNK, B_MW);
    cyc("j_f", 0, 1, 0, 0, I_J, VFA);
    chk_cnt("sw_cnt", 4'd9);
    cyc("j_d", 0, 0, 0, 0, I_JUNK, VZ);
    cyc("j_e", 0, 0, 1, 0, I_JUNK, VJ);

    // Illegal opcode: sticky trap, no fetch, counter frozen; reset clears.
    cyc("ill_f", 0, 1, 0, 0, I_BAD, VFA);
    chk_cnt("j_cnt", 4'd10);
    cyc("ill_d", 0, 0, 0, 0, I_BAD, VZ);
    cyc("ill_t0", 0, 1, 1, 0, I_J, B_ILL);
    cyc("ill_t1", 0, 1, 1, 0, I_J, B_ILL);
    cyc("ill_t2", 0, 0, 0, 0, I_J, B_ILL);
    chk_cnt("ill_cnt", 4'd10);
    cyc("ill_rst", 1, 0, 0, 0, I_J, VZ);
    chk_cnt("ill_rst_cnt", 4'd0);

    // sw with no ack: 16 MEMORY cycles then bus_error trap.
    cyc("swto_f", 0, 1, 0, 0, I_SW, VFA);
    cyc("swto_d", 0, 0, 0, 0, I_JUNK, VZ);
    cyc("swto_e", 0, 0, 0, 0, I_JUNK, VEX_IMM);
    for (int i = 0; i < 16; i++) begin
      cyc($sformatf("swto_m%0d", i), 0, 0, 0, 0, I_JUNK, B_MW);
    end
    cyc("swto_t0", 0, 1, 1, 0, I_JUNK, B_BE);
    cyc("swto_t1", 0, 0, 0, 0, I_JUNK, B_BE);
    chk_cnt("swto_cnt", 4'd0);
    cyc("swto_rst", 1, 0, 0, 0, I_JUNK, VZ);

    // sw acked on the 16th MEMORY cycle: ack wins, back to FETCH.
    cyc("sw16_f", 0, 1, 0, 0, I_SW, VFA);
    cyc("sw16_d", 0, 0, 0, 0, I_JUNK, VZ);
    cyc("sw16_e", 0, 0, 0, 0, I_JUNK, VEX_IMM);
    for (int i = 0; i < 15; i++) begin
      cyc($sformatf("sw16_m%0d", i), 0, 0, 0, 0, I_JUNK, B_MW);
    end
    cyc("sw16_m15", 0, 0, 1, 0, I_JUNK, B_MW);
    cyc("sw16_next", 0, 0, 0, 0, I_JUNK, VF);
    chk_cnt("sw16_cnt", 4'd1);

    // Reset while lw is waiting in MEMORY: request dropped, FETCH next.
    cyc("lwr_f", 0, 1, 0, 0, I_LW, VFA);
    cyc("lwr_d", 0, 0, 0, 0, I_JUNK, VZ);
    cyc("lwr_e", 0, 0, 0, 0, I_JUNK, VEX_IMM);
    cyc("lwr_m0", 0, 0, 0, 0, I_JUNK, B_MR);
    cyc("lwr_m1", 0, 0, 0, 0, I_JUNK, B_MR);
    cyc("lwr_rst", 1, 0, 0, 0, I_JUNK, VZ);
    chk_cnt("lwr_rst_cnt", 4'd0);
    cyc("lwr_next", 0, 0, 1, 0, I_JUNK, VF);
    chk_cnt("lwr_next_cnt", 4'd0);

    // 17 jumps into a 4-bit counter: wraps to 1.
    for (int i = 0; i < 17; i++) begin
      cyc($sformatf("wrap_f%0d", i), 0, 1, 0, 0, I_J, VFA);
      cyc($sformatf("wrap_d%0d", i), 0, 0, 0, 0, I_JUNK, VZ);
      cyc($sformatf("wrap_e%0d", i), 0, 0, 0, 0, I_JUNK, VJ);
    end
    cyc("wrap_next", 0, 0, 0, 0, I_JUNK, VF);
    chk_cnt("wrap_cnt", 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
